synapse_uart_tx: RTL and testbench

Register-mapped serial transmitter that consumes one Synapse316 output register. The CPU writes a byte to the register; the block queues it in a small FIFO and shifts it out as 8N1 serial on `txd`. A status word returns to the CPU through one `data_in_flat` slot, so firmware can poll for space and completion.

---
 rtl/synapse_uart_tx.sv | 168 ++++++++++++++++
 tb/tb_synapse_uart_tx.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/synapse_uart_tx.sv
// Register-mapped 8N1 serial transmitter: CPU writes queue bytes in a small FIFO,
// and a status word reports full/empty/activity/overflow/count back to the CPU.
module synapse_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4,
  parameter int FIFO_AW      = 2
) (
  input  logic        sysclk,
  input  logic        sysreset,
  input  logic [15:0] wr_data,
  input  logic        wr_load,
  output logic [15:0] status_out,
  output logic        txd,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  localparam logic [15:0]      BAUD_RELOAD = 16'(CLKS_PER_BIT - 1);
  localparam logic [FIFO_AW:0] FULL_COUNT  = (FIFO_AW + 1)'(FIFO_DEPTH);

  logic [7:0]         mem_q [FIFO_DEPTH];
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW:0]   count_q, count_d;
  logic               overflow_q, overflow_d;

  tx_state_e          state_q, state_d;
  logic [15:0]        baud_q, baud_d;
  logic [2:0]         bit_idx_q, bit_idx_d;
  logic [7:0]         shift_q, shift_d;
  logic               txd_q, txd_d;

  logic fifo_full, fifo_empty, tx_active;
  logic push_req, cmd_req, push, pop;
  logic unused_wr_bits;

  assign fifo_full  = (count_q == FULL_COUNT);
  assign fifo_empty = (count_q == '0);
  assign tx_active  = (state_q != ST_IDLE);

  assign cmd_req  = wr_load &  wr_data[15];
  assign push_req = wr_load & ~wr_data[15];
  // A push into a full FIFO is only safe when the FSM frees a slot in the same cycle.
  assign push     = push_req & (~fifo_full | pop);

  assign unused_wr_bits = ^wr_data[14:8];

  // FIFO bookkeeping
  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (cmd_req) begin
      overflow_d = 1'b0;
    end else if (push_req && !push) begin
      overflow_d = 1'b1;
    end
  end

  // Transmit FSM; txd_d is computed alongside the state so the line changes on the same edge.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    txd_d     = txd_q;
    pop       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        txd_d = 1'b1;
        if (!fifo_empty) begin
          pop       = 1'b1;
          shift_d   = mem_q[rd_ptr_q];
          baud_d    = BAUD_RELOAD;
          bit_idx_d = '0;
          state_d   = ST_START;
          txd_d     = 1'b0;
        end
      end
      ST_START: begin
        if (baud_q == '0) begin
          baud_d  = BAUD_RELOAD;
          state_d = ST_DATA;
          txd_d   = shift_q[0];
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      ST_DATA: begin
        if (baud_q == '0) begin
          baud_d    = BAUD_RELOAD;
          shift_d   = shift_q >> 1;
          bit_idx_d = bit_idx_q + 1'b1;
          if (bit_idx_q == 3'd7) begin
            state_d = ST_STOP;
            txd_d   = 1'b1;
          end else begin
            txd_d = shift_q[1];
          end
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      ST_STOP: begin
        if (baud_q == '0) begin
          state_d = ST_IDLE;
          txd_d   = 1'b1;
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        txd_d   = 1'b1;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge sysclk or negedge sysreset) begin
    if (!sysreset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      state_q    <= ST_IDLE;
      baud_q     <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      txd_q      <= 1'b1;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      txd_q      <= txd_d;
    end
  end

  // NOTE: the byte storage has no reset; entries are only read when count says they are valid.
  always_ff @(posedge sysclk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data[7:0];
  end

  assign status_out = {{(16 - 5 - FIFO_AW){1'b0}}, count_q, overflow_q, tx_active,
                       fifo_empty, fifo_full};
  assign txd        = txd_q;
  assign busy       = tx_active | ~fifo_empty;

endmodule

// File: tb/tb_synapse_uart_tx.sv
// Directed bench for synapse_uart_tx at CLKS_PER_BIT=4, FIFO_DEPTH=4: reset, single frame,
// fill/overflow, overflow clear, push+pop at full, and asynchronous reset mid-frame.
module tb_synapse_uart_tx;

  localparam int CPB = 4;

  logic        sysclk;
  logic        sysreset;
  logic [15:0] wr_data;
  logic        wr_load;
  logic [15:0] status_out;
  logic        txd;
  logic        busy;

  int checks = 0;
  int errors = 0;

  synapse_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (4),
    .FIFO_AW     (2)
  ) dut (
    .sysclk    (sysclk),
    .sysreset  (sysreset),
    .wr_data   (wr_data),
    .wr_load   (wr_load),
    .status_out(status_out),
    .txd       (txd),
    .busy      (busy)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 ns past it.
  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic write_reg(input logic [15:0] value);
    wr_data = value;
    wr_load = 1'b1;
    tick();
    wr_load = 1'b0;
    wr_data = 16'h0000;
  endtask

  // Cell index 0 is the cycle right after the edge that drove the start bit low.
  task automatic expect_cells(input logic [7:0] value, input int first, input int last);
    logic exp_bit;
    int   b;
    for (int idx = first; idx <= last; idx++) begin
      b = idx / CPB;
      if (b == 0)      exp_bit = 1'b0;
      else if (b == 9) exp_bit = 1'b1;
      else             exp_bit = value[b-1];
      check($sformatf("txd byte %h cell %0d", value, idx), {15'd0, txd}, {15'd0, exp_bit});
      tick();
    end
  endtask

  // One idle cycle, then a full frame: enforces 10*CPB+1 start-to-start spacing.
  task automatic next_frame(input logic [7:0] value);
    check("idle gap txd", {15'd0, txd}, 16'h0001);
    tick();
    expect_cells(value, 0, 10 * CPB - 1);
  endtask

  initial begin
    sysreset = 1'b0;
    wr_load  = 1'b0;
    wr_data  = 16'h0000;

    // Reset values
    repeat (3) tick();
    check("reset txd", {15'd0, txd}, 16'h0001);
    check("reset busy", {15'd0, busy}, 16'h0000);
    check("reset status", status_out, 16'h0002);
    sysreset = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      check("idle txd after reset", {15'd0, txd}, 16'h0001);
    end
    check("idle status", status_out, 16'h0002);

    // Single byte 0xA5
    write_reg(16'h00A5);
    check("single pushed status", status_out, 16'h0010);
    check("single pushed txd", {15'd0, txd}, 16'h0001);
    check("single pushed busy", {15'd0, busy}, 16'h0001);
    tick();
    check("single start status", status_out, 16'h0006);
    expect_cells(8'hA5, 0, 10 * CPB - 1);
    check("single done txd", {15'd0, txd}, 16'h0001);
    check("single done busy", {15'd0, busy}, 16'h0000);
    check("single done status", status_out, 16'h0002);

    // Fill and overflow: 0x11 popped at E1, 0x12..0x15 fill the queue, 0x16 dropped
    write_reg(16'h0011);
    check("fill first start txd", {15'd0, txd}, 16'h0001);
    write_reg(16'h0012);
    check("fill E1 txd low", {15'd0, txd}, 16'h0000);
    write_reg(16'h0013);
    write_reg(16'h0014);
    write_reg(16'h0015);
    write_reg(16'h0016);
    check("overflow status", status_out, 16'h004D);

    // Overflow clear: command write leaves count alone
    write_reg(16'h8000);
    check("overflow clear status", status_out, 16'h0045);
    expect_cells(8'h11, 5, 10 * CPB - 1);
    check("full idle status", status_out, 16'h0041);
    check("full idle txd", {15'd0, txd}, 16'h0001);

    // Push on the exact cycle the FSM pops at full
    write_reg(16'h0017);
    check("push+pop at full status", status_out, 16'h0045);
    expect_cells(8'h12, 0, 10 * CPB - 1);
    next_frame(8'h13);
    next_frame(8'h14);
    next_frame(8'h15);
    next_frame(8'h17);
    check("drain busy", {15'd0, busy}, 16'h0000);
    check("drain status", status_out, 16'h0002);
    for (int i = 0; i < 3 * CPB * 10; i++) begin
      tick();
      check("no extra frame txd", {15'd0, txd}, 16'h0001);
    end

    // Reset during data bit 3 of 0xC3 (bit 3 is 0, so the line is low)
    write_reg(16'h00C3);
    tick();
    expect_cells(8'hC3, 0, 4 * CPB + 1);
    check("pre-reset txd low", {15'd0, txd}, 16'h0000);
    #1 sysreset = 1'b0;
    #1;
    check("async reset txd", {15'd0, txd}, 16'h0001);
    check("async reset status", status_out, 16'h0002);
    check("async reset busy", {15'd0, busy}, 16'h0000);
    tick();
    tick();
    sysreset = 1'b1;
    for (int i = 0; i < 5 * CPB * 10; i++) begin
      tick();
      check("post-reset txd", {15'd0, txd}, 16'h0001);
    end
    check("post-reset status", status_out, 16'h0002);
    check("post-reset busy", {15'd0, busy}, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
